// File: rtl/sha1_padder_if.sv
// Message byte stream in, message-RAM word writes and status out for the SHA-1 padder.
interface sha1_padder_if;
  logic        start;
  logic [7:0]  msg_byte;
  logic        msg_valid;
  logic        msg_last;
  logic        msg_ready;
  logic [6:0]  waddr;
  logic        we;
  logic [31:0] din;
  logic [3:0]  num_chunks;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output start, msg_byte, msg_valid, msg_last,
    input  msg_ready, waddr, we, din, num_chunks, busy, done, error
  );

  modport slave (
    input  start, msg_byte, msg_valid, msg_last,
    output msg_ready, waddr, we, din, num_chunks, busy, done, error
  );
endinterface

// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs bytes big-endian into RAM words, appends 0x80, zero fill and 64-bit length.
// Writes appear one cycle after the accepting edge; msg_ready is high only while collecting, input stalls freely.
module sha1_padder (
  input  logic          clk,
  input  logic          rst_n,
  sha1_padder_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE, COLLECT, PAD80, ZERO, LEN_HI, LEN_LO, DONE, ERR
  } state_t;

  state_t      state, state_nx;
  logic [8:0]  byte_cnt, cnt_nx;
  logic [31:0] acc, acc_nx;
  logic [6:0]  widx, widx_nx;
  logic        we_q, we_nx;
  logic [6:0]  waddr_q, waddr_nx;
  logic [31:0] din_q, din_nx;
  logic [3:0]  chunks_q, chunks_nx;
  logic        done_q, done_nx;
  logic        error_q, error_nx;

  logic        do_wr;
  logic [31:0] wr_dat;
  logic        go;
  logic [4:0]  sh;
  logic [31:0] merged;
  logic [31:0] padded;
  logic [7:0]  nxt_idx;

  // Lane n of a word sits at bit 8*(3-n); ~lane equals 3-lane for a 2-bit lane.
  assign sh      = {~byte_cnt[1:0], 3'b000};
  assign merged  = acc | ({24'd0, bus.msg_byte} << sh);
  assign padded  = merged | ((32'h0000_0080 << sh) >> 8);
  assign nxt_idx = {1'b0, widx} + 8'd1;

  always_comb begin
    state_nx  = state;
    cnt_nx    = byte_cnt;
    acc_nx    = acc;
    widx_nx   = widx;
    we_nx     = 1'b0;
    waddr_nx  = waddr_q;
    din_nx    = din_q;
    chunks_nx = chunks_q;
    done_nx   = 1'b0;
    error_nx  = error_q;
    do_wr     = 1'b0;
    wr_dat    = 32'd0;
    go        = 1'b0;

    case (state)
      IDLE:    go = bus.start;
      COLLECT: begin
        if (bus.msg_valid) begin
          if (byte_cnt == 9'd503) begin
            error_nx = 1'b1;
            state_nx = ERR;
          end else begin
            cnt_nx = byte_cnt + 9'd1;
            if (bus.msg_last) begin
              do_wr    = 1'b1;
              wr_dat   = padded;
              acc_nx   = 32'd0;
              state_nx = (byte_cnt[1:0] == 2'd3) ? PAD80 : ZERO;
            end else if (byte_cnt[1:0] == 2'd3) begin
              do_wr  = 1'b1;
              wr_dat = merged;
              acc_nx = 32'd0;
            end else begin
              acc_nx = merged;
            end
          end
        end
      end
      PAD80: begin
        do_wr    = 1'b1;
        wr_dat   = 32'h8000_0000;
        state_nx = ZERO;
      end
      ZERO: begin
        // Fill up to the word just before the two length words of this chunk.
        if (widx[3:0] != 4'd14) begin
          do_wr = 1'b1;
          if (widx[3:0] == 4'd13) state_nx = LEN_HI;
        end else begin
          state_nx = LEN_HI;
        end
      end
      LEN_HI: begin
        do_wr    = 1'b1;
        state_nx = LEN_LO;
      end
      LEN_LO: begin
        do_wr     = 1'b1;
        wr_dat    = {20'd0, byte_cnt, 3'b000};
        chunks_nx = nxt_idx[7:4];
        done_nx   = 1'b1;
        state_nx  = DONE;
      end
      DONE: begin
        go       = bus.start;
        state_nx = IDLE;
      end
      ERR:     go = bus.start;
      default: state_nx = IDLE;
    endcase

    if (do_wr) begin
      we_nx    = 1'b1;
      din_nx   = wr_dat;
      waddr_nx = widx;
      widx_nx  = widx + 7'd1;
    end

    if (go) begin
      state_nx  = COLLECT;
      cnt_nx    = 9'd0;
      acc_nx    = 32'd0;
      widx_nx   = 7'd0;
      chunks_nx = 4'd0;
      error_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      byte_cnt <= 9'd0;
      acc      <= 32'd0;
      widx     <= 7'd0;
      we_q     <= 1'b0;
      waddr_q  <= 7'd0;
      din_q    <= 32'd0;
      chunks_q <= 4'd0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      byte_cnt <= cnt_nx;
      acc      <= acc_nx;
      widx     <= widx_nx;
      we_q     <= we_nx;
      waddr_q  <= waddr_nx;
      din_q    <= din_nx;
      chunks_q <= chunks_nx;
      done_q   <= done_nx;
      error_q  <= error_nx;
    end
  end

  assign bus.msg_ready  = (state == COLLECT);
  assign bus.busy       = (state != IDLE);
  assign bus.we         = we_q;
  assign bus.waddr      = waddr_q;
  assign bus.din        = din_q;
  assign bus.num_chunks = chunks_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
endmodule

// File: tb/tb_sha1_padder.sv
// Bench for sha1_padder: table vectors on the classic padding boundaries, corner sequences, random messages.
module tb_sha1_padder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sha1_padder_if bus ();
  sha1_padder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [31:0] ram [0:127];
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [7:0] msg [0:511];

  typedef struct {
    int          n;
    int          idx;
    logic [31:0] mask;
    logic [31:0] exp;
    int          chunks;
  } vec_t;
  vec_t tv [13];

  always @(negedge clk) begin
    if (bus.we) begin
      ram[bus.waddr] = bus.din;
      wr_cnt++;
    end
    if (bus.done) done_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: message, 0x80, zeros, 64-bit big-endian bit length, rounded up to 64-byte chunks.
  function automatic logic [31:0] model_word(input int n, input int idx);
    int total;
    logic [63:0] bl;
    logic [31:0] w;
    logic [7:0] b;
    total = ((n + 8) / 64 + 1) * 64;
    bl = 64'(n) * 64'd8;
    w = 32'd0;
    for (int k = 0; k < 4; k++) begin
      int p;
      p = idx * 4 + k;
      if (p < n)                b = msg[p];
      else if (p == n)          b = 8'h80;
      else if (p >= total - 8)  b = 8'(bl >> (8 * (total - 1 - p)));
      else                      b = 8'h00;
      w = {w[23:0], b};
    end
    return w;
  endfunction

  task automatic start_msg();
    for (int i = 0; i < 128; i++) ram[i] = 32'hDEAD_BEEF;
    wr_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // mode 0: continuous, 1: random gaps, 2: valid toggles every cycle
  task automatic feed(input int n, input int mode, input bit with_last);
    int idx, cyc;
    bit gap;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      gap = (mode == 1) ? ($urandom_range(0, 2) == 0) : (mode == 2) ? (cyc % 2 == 0) : 1'b0;
      if (gap) begin
        bus.msg_valid = 1'b0;
        bus.msg_last  = 1'b0;
      end else begin
        bus.msg_valid = 1'b1;
        bus.msg_byte  = msg[idx];
        bus.msg_last  = with_last && (idx == n - 1);
      end
      if (bus.msg_valid && bus.msg_ready) idx++;
    end
    if (idx < n) chk("feed_timeout", 32'(idx), 32'(n));
    @(negedge clk);
    bus.msg_valid = 1'b0;
    bus.msg_last  = 1'b0;
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (done_cnt == 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic run(input int n, input int mode);
    start_msg();
    feed(n, mode, 1'b1);
    wait_done();
  endtask

  task automatic check_all(input int n, input string tag);
    int chunks;
    chunks = (n + 8) / 64 + 1;
    chk({tag, "_num_chunks"}, {28'd0, bus.num_chunks}, 32'(chunks));
    chk({tag, "_writes"}, 32'(wr_cnt), 32'(chunks * 16));
    for (int i = 0; i < chunks * 16; i++)
      chk($sformatf("%s_word%0d", tag, i), ram[i], model_word(n, i));
  endtask

  task automatic fill_pattern(input int n);
    for (int k = 0; k < n; k++) msg[k] = 8'(8'h61 + k);
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) msg[k] = 8'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.msg_ready}, 32'd0);
    chk({tag, "_we"}, {31'd0, bus.we}, 32'd0);
    chk({tag, "_waddr"}, {25'd0, bus.waddr}, 32'd0);
    chk({tag, "_din"}, bus.din, 32'd0);
    chk({tag, "_chunks"}, {28'd0, bus.num_chunks}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_error"}, {31'd0, bus.error}, 32'd0);
  endtask

  initial begin
    int last_n;
    int lens [6];
    bus.start = 1'b0;
    bus.msg_byte = 8'd0;
    bus.msg_valid = 1'b0;
    bus.msg_last = 1'b0;
    rst_n = 1'b0;

    tv[0]  = '{3,   0,   32'hFFFF_FFFF, 32'h6162_6380, 1};
    tv[1]  = '{3,   1,   32'hFFFF_FFFF, 32'h0000_0000, 1};
    tv[2]  = '{3,   14,  32'hFFFF_FFFF, 32'h0000_0000, 1};
    tv[3]  = '{3,   15,  32'hFFFF_FFFF, 32'h0000_0018, 1};
    tv[4]  = '{55,  13,  32'h0000_00FF, 32'h0000_0080, 1};
    tv[5]  = '{55,  14,  32'hFFFF_FFFF, 32'h0000_0000, 1};
    tv[6]  = '{55,  15,  32'hFFFF_FFFF, 32'h0000_01B8, 1};
    tv[7]  = '{56,  14,  32'hFFFF_FFFF, 32'h8000_0000, 2};
    tv[8]  = '{56,  15,  32'hFFFF_FFFF, 32'h0000_0000, 2};
    tv[9]  = '{56,  29,  32'hFFFF_FFFF, 32'h0000_0000, 2};
    tv[10] = '{56,  31,  32'hFFFF_FFFF, 32'h0000_01C0, 2};
    tv[11] = '{503, 125, 32'h0000_00FF, 32'h0000_0080, 8};
    tv[12] = '{503, 127, 32'hFFFF_FFFF, 32'h0000_0FB8, 8};

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    last_n = -1;
    for (int i = 0; i < 13; i++) begin
      if (tv[i].n != last_n) begin
        fill_pattern(tv[i].n);
        run(tv[i].n, 0);
        last_n = tv[i].n;
      end
      chk($sformatf("tv%0d_word%0d", i, tv[i].idx), ram[tv[i].idx] & tv[i].mask, tv[i].exp);
      chk($sformatf("tv%0d_chunks", i), {28'd0, bus.num_chunks}, 32'(tv[i].chunks));
    end

    // valid toggling over "abc"
    fill_pattern(3);
    run(3, 2);
    check_all(3, "abc_toggle");

    // overflow: 504 bytes with no last
    fill_random(504);
    start_msg();
    feed(504, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("ovf_error", {31'd0, bus.error}, 32'd1);
    chk("ovf_ready", {31'd0, bus.msg_ready}, 32'd0);
    chk("ovf_busy", {31'd0, bus.busy}, 32'd1);
    chk("ovf_writes", 32'(wr_cnt), 32'd125);
    chk("ovf_word125", ram[125], 32'hDEAD_BEEF);
    fill_pattern(3);
    run(3, 0);
    chk("ovf_error_cleared", {31'd0, bus.error}, 32'd0);
    check_all(3, "after_ovf");

    // reset in the middle of a message
    fill_random(20);
    start_msg();
    feed(6, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    fill_pattern(3);
    run(3, 0);
    check_all(3, "after_rst");

    // boundary lengths then random lengths, random data
    lens = '{1, 4, 63, 64, 119, 120};
    for (int i = 0; i < 6; i++) begin
      fill_random(lens[i]);
      run(lens[i], 0);
      check_all(lens[i], $sformatf("len%0d", lens[i]));
    end
    for (int i = 0; i < 6; i++) begin
      int n;
      n = $urandom_range(1, 503);
      fill_random(n);
      run(n, 1);
      check_all(n, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
